// File: rtl/dcb_pkg.sv
// Shared types for the data capture buffer.
package dcb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } dcb_state_e;

endpackage : dcb_pkg

// File: rtl/dcb_storage.sv
// Sample storage: one synchronous write port, one asynchronous read port, no reset.
module dcb_storage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one sample per enabled cycle; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the addressed sample.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule : dcb_storage

// File: rtl/data_capture_buffer.sv
// Burst capture buffer: a start pulse records a run-time-sized burst of consecutive
// samples, which are then drained in order over a valid/ready stream.
module data_capture_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             data_start,
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    cap_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overrun
);

  import dcb_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  dcb_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    eff_len_q, eff_len_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic             we;
  logic [WIDTH-1:0] rd_data;
  logic [LW-1:0]    req_len;
  logic [LW-1:0]    last_idx;
  logic             wr_last;
  logic             rd_last;

  dcb_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Requested length folding and last-index detection for both pointers.
  always_comb begin
    req_len  = ((cap_len == '0) || (cap_len > LW'(DEPTH))) ? LW'(DEPTH) : cap_len;
    last_idx = eff_len_q - 1'b1;
    wr_last  = (LW'(wr_ptr_q) == last_idx);
    rd_last  = (LW'(rd_ptr_q) == last_idx);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (data_start) state_d = (req_len == LW'(1)) ? DRAIN : CAPTURE;
        CAPTURE: if (wr_last) state_d = DRAIN;
        DRAIN:   if (out_ready && rd_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pointer, length and flag updates. The write pointer returns to 0 on the final
  // write so it never reaches DEPTH; the write address is wr_ptr_q, which is 0 in IDLE.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    eff_len_d = eff_len_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    we        = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_start) begin
            we        = 1'b1;
            eff_len_d = req_len;
            overrun_d = 1'b0;
            if (req_len == LW'(1)) begin
              wr_ptr_d = '0;
              done_d   = 1'b1;
            end else begin
              wr_ptr_d = AW'(1);
            end
          end
        end
        CAPTURE: begin
          we = 1'b1;
          if (data_start) overrun_d = 1'b1;
          if (wr_last) begin
            wr_ptr_d = '0;
            done_d   = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (data_start) overrun_d = 1'b1;
          if (out_ready) begin
            rd_ptr_d = rd_last ? '0 : rd_ptr_q + 1'b1;
          end
        end
        default: begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      eff_len_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      eff_len_q <= eff_len_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decoded from state; out_data is forced to 0 outside DRAIN.
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == DRAIN);
    out_last  = out_valid && rd_last;
    out_data  = out_valid ? rd_data : '0;
    done      = done_q;
    overrun   = overrun_q;
  end

endmodule : data_capture_buffer

// File: tb/tb_data_capture_buffer.sv
// Self-checking bench for data_capture_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_data_capture_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             data_start = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [LW-1:0]    cap_len = '0;
  logic             out_ready = 1'b0;
  logic             busy, done, out_valid, out_last, overrun;
  logic [WIDTH-1:0] out_data;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  data_capture_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .data_start (data_start),
    .data       (data),
    .cap_len    (cap_len),
    .busy       (busy),
    .done       (done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: captured samples pending, samples awaiting drain, remaining captures.
  logic [WIDTH-1:0] cap_m[$];
  logic [WIDTH-1:0] drain_m[$];
  int               need_m = 0;
  bit               done_m = 1'b0;
  bit               ovr_m  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_m.delete();
      drain_m.delete();
      need_m = 0;
      done_m = 1'b0;
      ovr_m  = 1'b0;
    end else begin
      done_m = 1'b0;
      if (clear) begin
        cap_m.delete();
        drain_m.delete();
        need_m = 0;
      end else if (need_m == 0 && drain_m.size() == 0) begin
        if (data_start) begin
          int len;
          len = (cap_len == 0 || int'(cap_len) > DEPTH) ? DEPTH : int'(cap_len);
          cap_m.delete();
          cap_m.push_back(data);
          need_m = len - 1;
          ovr_m  = 1'b0;
          if (need_m == 0) begin
            drain_m = cap_m;
            cap_m.delete();
            done_m = 1'b1;
          end
        end
      end else begin
        if (data_start) ovr_m = 1'b1;
        if (need_m > 0) begin
          cap_m.push_back(data);
          need_m--;
          if (need_m == 0) begin
            drain_m = cap_m;
            cap_m.delete();
            done_m = 1'b1;
          end
        end else if (out_ready) begin
          void'(drain_m.pop_front());
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      bit         v;
      logic [WIDTH-1:0] d;
      v = (drain_m.size() != 0);
      d = v ? drain_m[0] : '0;
      check("m_busy",      busy,      (need_m > 0) || v);
      check("m_done",      done,      done_m);
      check("m_out_valid", out_valid, v);
      check("m_out_data",  out_data,  d);
      check("m_out_last",  out_last,  v && (drain_m.size() == 1));
      check("m_overrun",   overrun,   ovr_m);
    end
  end

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic start_burst(input logic [LW-1:0] len, input logic [WIDTH-1:0] d0);
    @(negedge clock);
    data_start = 1'b1;
    cap_len    = len;
    data       = d0;
    @(negedge clock);
    data_start = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_t2 [4];
    int hs;
    exp_t2[0] = 16'hA0A0; exp_t2[1] = 16'hB1B1; exp_t2[2] = 16'hC2C2; exp_t2[3] = 16'hD3D3;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, 16'h0);

    // T1: async reset mid-capture.
    start_burst(4'd8, 16'h1111);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_valid", out_valid, 1'b0);
    check("t1_done_ovr", {done, overrun, out_last}, 3'b000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t1_idle_after", busy, 1'b0);

    // T2: length 4, samples A..E, consumer always ready.
    out_ready = 1'b1;
    data_start = 1'b1; cap_len = 4'd4; data = exp_t2[0];
    @(negedge clock); data_start = 1'b0; data = exp_t2[1];
    @(negedge clock); data = exp_t2[2];
    @(negedge clock); data = exp_t2[3];
    @(negedge clock); data = 16'hE4E4;
    #1;
    check("t2_done", done, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clock);
        #1;
        check("t2_done_low", done, 1'b0);
      end
      check("t2_valid", out_valid, 1'b1);
      check("t2_data", out_data, exp_t2[i]);
      check("t2_last", out_last, (i == 3));
    end
    @(negedge clock);
    #1;
    check("t2_valid_drop", out_valid, 1'b0);

    // T3: length 0 means DEPTH, ready toggling.
    @(negedge clock);
    data_start = 1'b1; cap_len = 4'd0; data = 16'h5000; out_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      data_start = 1'b0;
      data = 16'h5000 + 16'(i);
    end
    hs = 0;
    for (int c = 0; c < 40 && (busy === 1'b1 || c == 0); c++) begin
      @(negedge clock);
      out_ready = (c % 2 == 0);
      #1;
      if (out_valid && out_ready) hs++;
    end
    check("t3_handshakes", hs, 8);
    wait_idle(10);

    // T4: single-sample burst.
    out_ready = 1'b1;
    start_burst(4'd1, 16'h4444);
    #1;
    check("t4_flags", {done, out_valid, out_last}, 3'b111);
    check("t4_data", out_data, 16'h4444);
    @(negedge clock);

    // T5: overrun during capture and drain.
    out_ready = 1'b0;
    start_burst(4'd6, 16'h6000);
    data = 16'h6001;
    data_start = 1'b1;
    @(negedge clock); data_start = 1'b0; data = 16'h6002;
    #1;
    check("t5_ovr_capture", overrun, 1'b1);
    for (int i = 3; i < 6; i++) begin
      @(negedge clock); data = 16'h6000 + 16'(i);
    end
    @(negedge clock);
    data_start = 1'b1;
    @(negedge clock);
    data_start = 1'b0;
    #1;
    check("t5_ovr_drain", overrun, 1'b1);
    check("t5_still_first", out_data, 16'h6000);
    out_ready = 1'b1;
    wait_idle(20);
    start_burst(4'd2, 16'h7000);
    #1;
    check("t5_ovr_cleared", overrun, 1'b0);
    wait_idle(10);

    // T6: clear in DRAIN with ready low, then clear+start together in IDLE.
    out_ready = 1'b0;
    start_burst(4'd3, 16'h8000);
    repeat (3) @(negedge clock);
    #1;
    check("t6_in_drain", out_valid, 1'b1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("t6_cleared", {busy, out_valid, out_last, done}, 4'b0000);
    clear = 1'b1; data_start = 1'b1; cap_len = 4'd2;
    @(negedge clock);
    clear = 1'b0; data_start = 1'b0;
    #1;
    check("t6_no_start", {busy, out_valid}, 2'b00);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      clear      = ($urandom_range(0, 99) < 3);
      data_start = ($urandom_range(0, 99) < 15);
      cap_len    = LW'($urandom_range(0, 15));
      data       = WIDTH'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
    end
    @(negedge clock);
    clear = 1'b0; data_start = 1'b0; out_ready = 1'b1;
    wait_idle(30);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_capture_buffer
